// File: rtl/missile_pkg.sv
// Shared types and defaults for the player missile.
// COOLDOWN is present only when MISSILE_COOLDOWN_EN is defined.
package missile_pkg;

  localparam int STEP_DEF     = 4;
  localparam int Y_START_DEF  = 440;
  localparam int Y_MIN_DEF    = 0;
  localparam int COOLDOWN_DEF = 15;

  localparam logic [7:0] FIRE_KEY = 8'h2C;

  typedef enum logic [1:0] {
    IDLE,
    FLIGHT,
`ifdef MISSILE_COOLDOWN_EN
    HIT,
    COOLDOWN
`else
    HIT
`endif
  } state_t;

endpackage

// File: rtl/box_hit_check.sv
// Axis-aligned overlap of a point against a box given by
// center and half-size; pure combinational.
module box_hit_check (
  input  logic [9:0] ax,
  input  logic [9:0] ay,
  input  logic [9:0] bx,
  input  logic [9:0] by,
  input  logic [9:0] sx,
  input  logic [9:0] sy,
  output logic       overlap
);

  logic [10:0] dx;
  logic [10:0] dy;

  // Larger minus smaller, so the distance never wraps.
  always_comb begin
    if (ax >= bx) dx = {1'b0, ax} - {1'b0, bx};
    else          dx = {1'b0, bx} - {1'b0, ax};
    if (ay >= by) dy = {1'b0, ay} - {1'b0, by};
    else          dy = {1'b0, by} - {1'b0, ay};
  end

  assign overlap = (dx <= {1'b0, sx})
                && (dy <= {1'b0, sy});

endmodule

// File: rtl/player_missile.sv
// Player missile: edge-triggered fire, upward flight, hit detection.
// Define MISSILE_COOLDOWN_EN to block refire after each shot.
module player_missile
  import missile_pkg::*;
#(
  parameter int MISSILE_STEP    = STEP_DEF,
  parameter int MISSILE_Y_START = Y_START_DEF,
  parameter int MISSILE_Y_MIN   = Y_MIN_DEF,
  parameter int COOLDOWN_FRAMES = COOLDOWN_DEF
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic [9:0] ShipX,
  input  logic [9:0] AlienX,
  input  logic [9:0] AlienY,
  input  logic [9:0] AlienSX,
  input  logic [9:0] AlienSY,
  output logic [9:0] MissileX,
  output logic [9:0] MissileY,
  output logic       MissileActive,
  output logic       Hit,
  output logic [7:0] HitCount
);

  localparam logic [9:0]  Y_START = 10'(MISSILE_Y_START);
  localparam logic [9:0]  STEP    = 10'(MISSILE_STEP);
  localparam logic [10:0] Y_EXIT  =
    11'(MISSILE_Y_MIN + MISSILE_STEP);

`ifdef MISSILE_COOLDOWN_EN
  localparam int CDW = (COOLDOWN_FRAMES < 1) ? 1 :
    $clog2(COOLDOWN_FRAMES + 1);
  localparam logic [CDW-1:0] CD_LOAD = CDW'(COOLDOWN_FRAMES);
  localparam state_t END_ST = COOLDOWN;
  logic [CDW-1:0] cd_q, cd_d;
`else
  localparam state_t END_ST = IDLE;
`endif

  state_t     state_q, state_d;
  logic [7:0] prev_key;
  logic [9:0] x_d, y_d;
  logic       act_d, hit_d;
  logic [7:0] cnt_d;
  logic       fire, overlap, at_top;

  box_hit_check u_hit (
    .ax      (MissileX),
    .ay      (MissileY),
    .bx      (AlienX),
    .by      (AlienY),
    .sx      (AlienSX),
    .sy      (AlienSY),
    .overlap (overlap)
  );

  assign fire   = (keycode == FIRE_KEY)
               && (prev_key != FIRE_KEY);
  assign at_top = {1'b0, MissileY} < Y_EXIT;

  always_comb begin
    state_d = state_q;
    x_d     = MissileX;
    y_d     = MissileY;
    act_d   = MissileActive;
    hit_d   = 1'b0;
    cnt_d   = HitCount;
`ifdef MISSILE_COOLDOWN_EN
    cd_d    = cd_q;
`endif
    unique case (state_q)
      IDLE: begin
        y_d = Y_START;
        if (fire) begin
          x_d     = ShipX;
          act_d   = 1'b1;
          state_d = FLIGHT;
        end
      end
      FLIGHT: begin
        if (overlap) begin
          state_d = HIT;
          hit_d   = 1'b1;
          act_d   = 1'b0;
          if (HitCount != 8'hFF)
            cnt_d = HitCount + 8'd1;
        end else if (at_top) begin
          act_d   = 1'b0;
          y_d     = Y_START;
          state_d = END_ST;
`ifdef MISSILE_COOLDOWN_EN
          cd_d    = CD_LOAD;
`endif
        end else begin
          y_d = MissileY - STEP;
        end
      end
      HIT: begin
        y_d     = Y_START;
        state_d = END_ST;
`ifdef MISSILE_COOLDOWN_EN
        cd_d    = CD_LOAD;
`endif
      end
`ifdef MISSILE_COOLDOWN_EN
      COOLDOWN: begin
        if (cd_q == '0) state_d = IDLE;
        else            cd_d    = cd_q - 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= IDLE;
      prev_key      <= 8'h00;
      MissileX      <= 10'd0;
      MissileY      <= Y_START;
      MissileActive <= 1'b0;
      Hit           <= 1'b0;
      HitCount      <= 8'h00;
`ifdef MISSILE_COOLDOWN_EN
      cd_q          <= '0;
`endif
    end else begin
      state_q       <= state_d;
      prev_key      <= keycode;
      MissileX      <= x_d;
      MissileY      <= y_d;
      MissileActive <= act_d;
      Hit           <= hit_d;
      HitCount      <= cnt_d;
`ifdef MISSILE_COOLDOWN_EN
      cd_q          <= cd_d;
`endif
    end
  end

endmodule

// File: tb/tb_player_missile.sv
// Self-checking bench for player_missile: vector table,
// hand-written reset, cooldown and saturation sequences.
module tb_player_missile;

  logic       frame_clk;
  logic       Reset;
  logic [7:0] keycode;
  logic [9:0] ShipX, AlienX, AlienY, AlienSX, AlienSY;
  logic [9:0] MissileX, MissileY;
  logic       MissileActive, Hit;
  logic [7:0] HitCount;

  player_missile dut (
    .frame_clk     (frame_clk),
    .Reset         (Reset),
    .keycode       (keycode),
    .ShipX         (ShipX),
    .AlienX        (AlienX),
    .AlienY        (AlienY),
    .AlienSX       (AlienSX),
    .AlienSY       (AlienSY),
    .MissileX      (MissileX),
    .MissileY      (MissileY),
    .MissileActive (MissileActive),
    .Hit           (Hit),
    .HitCount      (HitCount)
  );

`ifdef MISSILE_COOLDOWN_EN
  localparam int CDW = 16;
  localparam int GAP = 18;
`else
  localparam int CDW = 0;
  localparam int GAP = 2;
`endif

  typedef struct {
    string      name;
    logic [9:0] x, y;
    logic       a, h;
    logic [7:0] c;
  } exp_t;

  typedef struct {
    string      name;
    logic [7:0] key;
    logic [9:0] ship;
    int         n;
    logic [9:0] ex, ey;
    logic       ea, eh;
    logic [7:0] ec;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   hit_pulses = 0;
  int   prior;

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  always @(negedge frame_clk)
    if (Hit) hit_pulses++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge frame_clk);
    #1;
  endtask

  task automatic push(input string nm, input logic [9:0] x,
                      input logic [9:0] y, input logic a,
                      input logic h, input logic [7:0] c);
    exp_t e;
    e.name = nm; e.x = x; e.y = y;
    e.a = a; e.h = h; e.c = c;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard: empty queue");
      return;
    end
    e = sb.pop_front();
    if (MissileX !== e.x) begin
      n_bad++;
      $display("FAIL %s MissileX got %0d want %0d",
               e.name, MissileX, e.x);
    end
    if (MissileY !== e.y) begin
      n_bad++;
      $display("FAIL %s MissileY got %0d want %0d",
               e.name, MissileY, e.y);
    end
    if (MissileActive !== e.a) begin
      n_bad++;
      $display("FAIL %s MissileActive got %b want %b",
               e.name, MissileActive, e.a);
    end
    if (Hit !== e.h) begin
      n_bad++;
      $display("FAIL %s Hit got %b want %b",
               e.name, Hit, e.h);
    end
    if (HitCount !== e.c) begin
      n_bad++;
      $display("FAIL %s HitCount got %0d want %0d",
               e.name, HitCount, e.c);
    end
  endtask

  task automatic check_int(input string nm, input int got,
                           input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic step(input string nm, input logic [7:0] k,
                      input int n, input logic [9:0] x,
                      input logic [9:0] y, input logic a,
                      input logic h, input logic [7:0] c);
    keycode = k;
    push(nm, x, y, a, h, c);
    tick(n);
    pop_check();
  endtask

  initial begin
    tbl.push_back('{"launch",     8'h2C, 300, 1,
                    300, 440, 1, 0, 1'd0});
    tbl.push_back('{"step1",      8'h00, 300, 1,
                    300, 436, 1, 0, 0});
    tbl.push_back('{"edge80",     8'h00, 300, 79,
                    300, 120, 1, 0, 0});
    tbl.push_back('{"hit",        8'h00, 300, 1,
                    300, 120, 0, 1, 1});
    tbl.push_back('{"hit_end",    8'h00, 300, 1 + CDW,
                    300, 440, 0, 0, 1});
    tbl.push_back('{"relaunch",   8'h2C, 100, 1,
                    100, 440, 1, 0, 1});
    tbl.push_back('{"miss_y0",    8'h00, 100, 110,
                    100, 0, 1, 0, 1});
    tbl.push_back('{"top_exit",   8'h00, 100, 1 + CDW,
                    100, 440, 0, 0, 1});
    tbl.push_back('{"held_fire",  8'h2C, 100, 1,
                    100, 440, 1, 0, 1});
    tbl.push_back('{"held_y0",    8'h2C, 100, 110,
                    100, 0, 1, 0, 1});
    tbl.push_back('{"held_exit",  8'h2C, 100, 1,
                    100, 440, 0, 0, 1});
    tbl.push_back('{"held_idle",  8'h2C, 100, 88,
                    100, 440, 0, 0, 1});
    tbl.push_back('{"release",    8'h00, 100, 1,
                    100, 440, 0, 0, 1});
    tbl.push_back('{"repress",    8'h2C, 50, 1,
                    50, 440, 1, 0, 1});
    tbl.push_back('{"fly",        8'h00, 50, 1,
                    50, 436, 1, 0, 1});

    Reset = 1'b1;
    keycode = 8'h00;
    ShipX = 10'd300;
    AlienX = 10'd300; AlienY = 10'd100;
    AlienSX = 10'd25; AlienSY = 10'd20;
    #1;
    push("reset", 0, 440, 0, 0, 0);
    pop_check();
    #10;
    Reset = 1'b0;

    foreach (tbl[i]) begin
      ShipX   = tbl[i].ship;
      keycode = tbl[i].key;
      push(tbl[i].name, tbl[i].ex, tbl[i].ey,
           tbl[i].ea, tbl[i].eh, tbl[i].ec);
      tick(tbl[i].n);
      pop_check();
    end
    check_int("hit_pulses_after_miss", hit_pulses, 1);

    // Abort a shot in mid-flight with an async reset.
    keycode = 8'h00;
    tick(10);
    Reset = 1'b1;
    #1;
    push("reset_flight", 0, 440, 0, 0, 0);
    pop_check();
    check_int("no_hit_on_reset", hit_pulses, 1);
    Reset = 1'b0;

    ShipX = 10'd200;
    AlienX = 10'd200; AlienY = 10'd440;
    AlienSX = 10'd5; AlienSY = 10'd5;
    prior = 0;
`ifdef MISSILE_COOLDOWN_EN
    step("cd_shot",    8'h2C, 1, 200, 440, 1, 0, 0);
    step("cd_hit",     8'h00, 1, 200, 440, 0, 1, 1);
    tick(5);
    step("cd_ignored", 8'h2C, 1, 200, 440, 0, 0, 1);
    keycode = 8'h00;
    tick(12);
    step("cd_launch",  8'h2C, 1, 200, 440, 1, 0, 1);
    step("cd_hit2",    8'h00, 1, 200, 440, 0, 1, 2);
    tick(GAP - 1);
    prior = 2;
`endif

    for (int i = 0; i < 256 - prior; i++) begin
      keycode = 8'h2C;
      tick(1);
      if (i == 255 - prior) begin
        step("sat_hit", 8'h00, 1, 200, 440, 0, 1, 255);
        tick(GAP - 1);
      end else begin
        keycode = 8'h00;
        tick(GAP);
      end
      if (i == 254 - prior) begin
        push("sat_255", 200, 440, 0, 0, 255);
        pop_check();
      end
    end
    push("sat_final", 200, 440, 0, 0, 255);
    pop_check();
    check_int("total_hit_pulses", hit_pulses, 257);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
